tt_um_mult: RTL
===============

TT_UM_MULT -- requirements
Module: tt_um_mult

Interface
REQ-001 The block SHALL have parameter MAX_IN_LEN, default 16: number of activations / weight rows.
REQ-002 The block SHALL have parameter MAX_OUT_LEN, default 8: number of outputs / weight columns.
REQ-003 The block SHALL have parameter BIT_WIDTH_IN, default 8: signed activation width.
REQ-004 The block SHALL have parameter BIT_WIDTH_OUT, default 8: signed result width.
REQ-005 Port clk  input  1: single clock; all state SHALL change on its rising edge.
REQ-006 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 Port ena  input  1: block enable; low aborts any operation.
REQ-008 Port ui_input  input  BIT_WIDTH_IN: signed activation x[i].
REQ-009 Port in_valid  input  1: ui_input carries a valid activation this cycle.
REQ-010 Port ui_param  input  7: [6:3] = in_len-1, [2:0] = out_len-1.
REQ-011 Port weights  input  signed [1:0] [MAX_IN_LEN][MAX_OUT_LEN]: ternary matrix from the weight loader, held stable during operation.
REQ-012 Port uo_output  output  BIT_WIDTH_OUT: result y[j], registered.
REQ-013 Port uo_valid  output  1: uo_output valid this cycle.
REQ-014 Port uo_done  output  1: one-cycle pulse coincident with the last result.

Function
REQ-015 Weight decode SHALL be: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0; reserved 2'b10 = 0.
REQ-016 Accumulators acc[0..MAX_OUT_LEN-1] SHALL be ACC_W = BIT_WIDTH_IN+$clog2(MAX_IN_LEN)+1 bits signed (13 at defaults), so no overflow is possible.
REQ-017 The FSM SHALL have states IDLE, ACCUM, DRAIN.
REQ-018 IDLE: accumulators zero; on ena&in_valid, apply activation index 0 and go to ACCUM, or to DRAIN if ui_param[6:3]==0.
REQ-019 ACCUM: each ena&in_valid cycle SHALL add x[idx]*w[idx][j] to acc[j] for all j in parallel, then increment idx; when idx==ui_param[6:3] is accepted, go to DRAIN.
REQ-020 A cycle with in_valid low SHALL hold all state; bubbles SHALL NOT change results.
REQ-021 DRAIN: one result per cycle, j = 0..ui_param[2:0] in order, with uo_valid high; the first result SHALL appear the cycle after the last activation is accepted.
REQ-022 uo_done SHALL pulse with result j==ui_param[2:0]; the next cycle returns to IDLE with accumulators cleared.
REQ-023 in_valid during DRAIN SHALL be ignored; those activations are dropped.
REQ-024 ena low in any state SHALL return to IDLE next edge: accumulators and counters cleared, uo_valid and uo_done low, no partial results emitted.
REQ-025 Rows with index > ui_param[6:3] and columns > ui_param[2:0] SHALL never contribute or be emitted.
REQ-026 ui_param SHALL be sampled on the IDLE->ACCUM/DRAIN transition and held internally for the operation.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, acc, idx, and the output counter to 0, uo_output 0, uo_valid 0, and uo_done 0, including mid-ACCUM or mid-DRAIN.

Configuration
REQ-028 With TT_UM_MULT_SAT_EN defined, acc[j] SHALL be clamped to [-2^(BIT_WIDTH_OUT-1), 2^(BIT_WIDTH_OUT-1)-1] on output.
REQ-029 Without TT_UM_MULT_SAT_EN, uo_output SHALL be acc[j][BIT_WIDTH_OUT-1:0] (two's-complement wrap).

Structure
REQ-030 Shared package tt_um_pkg SHALL hold ternary encoding constants (W_ZERO, W_POS, W_NEG), the FSM state typedef, and the ACC_W derivation.
REQ-031 One sub-module tt_um_tmac SHALL implement a single column accumulator (decode, add/sub/hold, clear); tt_um_mult SHALL instantiate MAX_OUT_LEN copies.

Verification
REQ-032 All w=+1, ui_param=7'h7F, x=1..16 back-to-back -> eight results; SAT_EN: 127 each; no SAT_EN: -120 each; uo_done with the 8th.
REQ-033 All w=-1, ui_param={4'd3,3'd1}, x=5,5,5,5 -> exactly two results, -20 and -20; uo_done on the second; then IDLE.
REQ-034 w[0][0]=2'b10, others 0, x[0]=100, in_len=1 -> y[0]=0.
REQ-035 Same vector as REQ-033 with in_valid bubbles between every activation -> identical results and timing relative to the last accepted activation.
REQ-036 ena dropped after 3 of 16 activations -> no uo_valid and no uo_done; a following full run gives the correct results, with no residue.
REQ-037 rst_n asserted asynchronously during DRAIN -> uo_valid, uo_done, and uo_output go to 0 before the next clock edge.

Source files
------------

// File: rtl/tt_um_pkg.sv
// ---------------------------------------------------------------------------
// tt_um_pkg
// Shared definitions for the ternary-weight matrix-vector multiplier.
//   W_ZERO / W_POS / W_NEG / W_RSVD : 2-bit ternary weight encodings
//   state_t                         : control FSM states
//   acc_width()                     : accumulator width that cannot overflow
//                                     for a given input width and row count
// ---------------------------------------------------------------------------
package tt_um_pkg;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_RSVD = 2'b10;   // decodes as zero
    localparam logic [1:0] W_NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // |sum| <= max_in * 2^(bw_in-1), so one sign bit plus log2(rows) growth.
    function automatic int acc_width(input int bw_in, input int max_in);
        return bw_in + $clog2(max_in) + 1;
    endfunction

endpackage

// File: rtl/tt_um_tmac.sv
// ---------------------------------------------------------------------------
// tt_um_tmac
// One column accumulator of the ternary multiplier: decodes a 2-bit weight
// and adds, subtracts or holds the signed activation.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : accumulate this cycle
//   x          : signed activation
//   w          : ternary weight for this column and the current row
//   acc_next   : value acc takes at the next edge (combinational)
//   acc        : registered accumulator
// ---------------------------------------------------------------------------
module tt_um_tmac
    import tt_um_pkg::*;
#(
    parameter int BIT_WIDTH_IN = 8,
    parameter int ACC_W        = 13
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           en,
    input  logic signed [BIT_WIDTH_IN-1:0] x,
    input  logic        [1:0]              w,
    output logic signed [ACC_W-1:0]        acc_next,
    output logic signed [ACC_W-1:0]        acc
);

    logic signed [ACC_W-1:0] x_ext;

    always_comb begin
        x_ext    = {{(ACC_W-BIT_WIDTH_IN){x[BIT_WIDTH_IN-1]}}, x};
        acc_next = acc;
        if (clr) begin
            acc_next = '0;
        end else if (en) begin
            case (w)
                W_POS:   acc_next = acc + x_ext;
                W_NEG:   acc_next = acc - x_ext;
                default: acc_next = acc;   // W_ZERO and reserved W_RSVD
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/tt_um_mult.sv
// ---------------------------------------------------------------------------
// tt_um_mult
// Ternary-weight matrix-vector multiplier: y[j] = sum_i x[i] * w[i][j].
// Activations stream in one per accepted cycle; results stream out one per
// cycle, first result the cycle after the last activation is accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : enable; low aborts any operation and returns to IDLE
//   ui_input   : signed activation x[i]
//   in_valid   : ui_input valid this cycle
//   ui_param   : [6:3] = in_len-1, [2:0] = out_len-1 (sampled at start)
//   weights    : ternary matrix, held stable during an operation
//   uo_output  : registered result y[j]
//   uo_valid   : uo_output valid
//   uo_done    : pulses with the last result
//   dbg_state  : current FSM state (state_t encoding)
// Optional: define TT_UM_MULT_SAT_EN to clamp results to the output range
// instead of two's-complement wrap.
//
// Handshake: an activation is accepted on a rising edge where ena and
// in_valid are both high and the FSM is not in DRAIN; there is no back
// pressure, in_valid in DRAIN is simply dropped. uo_valid has no ready.
// ---------------------------------------------------------------------------
module tt_um_mult
    import tt_um_pkg::*;
#(
    parameter int MAX_IN_LEN    = 16,
    parameter int MAX_OUT_LEN   = 8,
    parameter int BIT_WIDTH_IN  = 8,
    parameter int BIT_WIDTH_OUT = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic signed [BIT_WIDTH_IN-1:0] ui_input,
    input  logic                           in_valid,
    input  logic        [6:0]              ui_param,
    input  logic signed [1:0]              weights [MAX_IN_LEN][MAX_OUT_LEN],
    output logic        [BIT_WIDTH_OUT-1:0] uo_output,
    output logic                           uo_valid,
    output logic                           uo_done,
    output logic        [1:0]              dbg_state
);

    localparam int ACC_W = acc_width(BIT_WIDTH_IN, MAX_IN_LEN);

    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  in_len_q;
    logic [2:0]  out_len_q;
    logic [2:0]  ocnt;

    logic        accept;
    logic        last_in;
    logic        drain_end;
    logic        clr;
    logic [3:0]  in_len_eff;
    logic [2:0]  out_len_eff;

    logic signed [ACC_W-1:0] acc      [MAX_OUT_LEN];
    logic signed [ACC_W-1:0] acc_nxt  [MAX_OUT_LEN];
    logic signed [ACC_W-1:0] sel_acc;
    logic [BIT_WIDTH_OUT-1:0] sel_out;

    assign dbg_state = state;

    // In IDLE the lengths are not latched yet, so the live ui_param is used.
    assign in_len_eff  = (state == IDLE) ? ui_param[6:3] : in_len_q;
    assign out_len_eff = (state == IDLE) ? ui_param[2:0] : out_len_q;

    assign accept    = ena && in_valid && (state != DRAIN);
    assign last_in   = accept && (idx == in_len_eff);
    assign drain_end = (state == DRAIN) && uo_done;
    assign clr       = !ena || drain_end;

    for (genvar j = 0; j < MAX_OUT_LEN; j++) begin : g_col
        logic col_en;
        // Columns beyond out_len never accumulate.
        assign col_en = accept && (3'(j) <= out_len_eff);

        tt_um_tmac #(
            .BIT_WIDTH_IN (BIT_WIDTH_IN),
            .ACC_W        (ACC_W)
        ) u_tmac (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .en       (col_en),
            .x        (ui_input),
            .w        (weights[idx][j]),
            .acc_next (acc_nxt[j]),
            .acc      (acc[j])
        );
    end

    // The first result is registered on the edge that accepts the last
    // activation, so it is taken from acc_next of column 0; later results
    // come from the settled accumulators.
    always_comb begin
        sel_acc = (state == DRAIN) ? acc[ocnt] : acc_nxt[0];
    end

`ifdef TT_UM_MULT_SAT_EN
    localparam int OMAX = (1 << (BIT_WIDTH_OUT-1)) - 1;
    localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(OMAX);
    localparam logic signed [ACC_W-1:0] ACC_LO = ACC_W'(-OMAX - 1);
    logic signed [ACC_W-1:0] clamped;

    always_comb begin
        clamped = sel_acc;
        if (sel_acc > ACC_HI) begin
            clamped = ACC_HI;
        end else if (sel_acc < ACC_LO) begin
            clamped = ACC_LO;
        end
        sel_out = clamped[BIT_WIDTH_OUT-1:0];
    end

    logic unused_hi;
    assign unused_hi = ^clamped[ACC_W-1:BIT_WIDTH_OUT];
`else
    always_comb begin
        sel_out = sel_acc[BIT_WIDTH_OUT-1:0];
    end

    logic unused_hi;
    assign unused_hi = ^sel_acc[ACC_W-1:BIT_WIDTH_OUT];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            in_len_q  <= '0;
            out_len_q <= '0;
            ocnt      <= '0;
            uo_output <= '0;
            uo_valid  <= 1'b0;
            uo_done   <= 1'b0;
        end else if (!ena) begin
            state     <= IDLE;
            idx       <= '0;
            in_len_q  <= '0;
            out_len_q <= '0;
            ocnt      <= '0;
            uo_output <= '0;
            uo_valid  <= 1'b0;
            uo_done   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    uo_valid <= 1'b0;
                    uo_done  <= 1'b0;
                    if (state == IDLE && accept) begin
                        in_len_q  <= ui_param[6:3];
                        out_len_q <= ui_param[2:0];
                    end
                    if (last_in) begin
                        state     <= DRAIN;
                        idx       <= '0;
                        uo_output <= sel_out;
                        uo_valid  <= 1'b1;
                        uo_done   <= (out_len_eff == 3'd0);
                        ocnt      <= 3'd1;
                    end else if (accept) begin
                        state <= ACCUM;
                        idx   <= idx + 4'd1;
                    end
                end
                DRAIN: begin
                    if (uo_done) begin
                        // Accumulators clear on this same edge via clr.
                        state     <= IDLE;
                        ocnt      <= '0;
                        uo_output <= '0;
                        uo_valid  <= 1'b0;
                        uo_done   <= 1'b0;
                    end else begin
                        uo_output <= sel_out;
                        uo_valid  <= 1'b1;
                        uo_done   <= (ocnt == out_len_q);
                        ocnt      <= ocnt + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
